// File: rtl/mux_pkg.sv
// Shared types and widths for the 16:1 mux and its serializer front end.
package mux_pkg;

  localparam int MUX_WIDTH = 16;
  localparam int SEL_W     = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/mux16to1.sv
// Plain 16:1 bit multiplexer: y is in[sel].
module mux16to1
  import mux_pkg::*;
(
  input  logic [SEL_W-1:0]     sel,
  input  logic [MUX_WIDTH-1:0] in,
  output logic                 y
);

  assign y = in[sel];

endmodule

// File: rtl/mux16_serializer.sv
// Parallel-to-serial front end: captures a 16-bit word and walks the mux select
// 0..15 so the word leaves LSB first, each bit held for BIT_CYCLES clocks.
module mux16_serializer
  import mux_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 1  // legal range 1..255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MUX_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [SEL_W-1:0]     sel,
  output logic                 y,
  output logic                 y_valid,
  output logic                 y_last,
  output logic                 busy
);

  localparam logic [7:0]       CNT_MAX  = 8'(BIT_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(MUX_WIDTH - 1);

  // Handshake: a word transfers on a rising edge where in_valid & in_ready are
  // both high; in_ready depends only on registered state, never on in_valid,
  // and the producer must hold in_data stable until that transfer happens.

  state_e                 state_q, state_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [MUX_WIDTH-1:0]   data_q, data_d;
  logic                   term_cnt;
  logic                   at_last;
  logic                   take;
  logic                   mux_y;

  assign term_cnt = (cnt_q == CNT_MAX);
  assign at_last  = (sel_q == SEL_LAST);
  assign in_ready = (state_q == IDLE) || ((state_q == SHIFT) && at_last && term_cnt);
  assign take     = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          data_d  = in_data;
          sel_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!term_cnt) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = '0;
          if (!at_last) begin
            sel_d = sel_q + SEL_W'(1);
          end else if (take) begin
            // Back-to-back: the next word starts with no idle bubble.
            data_d  = in_data;
            sel_d   = '0;
            state_d = SHIFT;
          end else begin
            sel_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  mux16to1 u_mux (
    .sel (sel_q),
    .in  (data_q),
    .y   (mux_y)
  );

  assign sel     = sel_q;
  assign busy    = (state_q == SHIFT);
  assign y_valid = busy;
  assign y_last  = busy && at_last;
  assign y       = mux_y && y_valid;

endmodule

// File: tb/tb_mux16_serializer.sv
// Directed bench for mux16_serializer: one instance with BIT_CYCLES=1, one with 3.
module tb_mux16_serializer;

  logic        clk;
  logic        rst;

  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready, y, y_valid, y_last, busy;
  logic [3:0]  sel;

  logic [15:0] in_data3;
  logic        in_valid3;
  logic        in_ready3, y3, y_valid3, y_last3, busy3;
  logic [3:0]  sel3;

  int assertions = 0;
  int failures   = 0;
  logic [0:0] exp_q[$];

  mux16_serializer #(.BIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .y(y), .y_valid(y_valid),
    .y_last(y_last), .busy(busy)
  );

  mux16_serializer #(.BIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .sel(sel3), .y(y3), .y_valid(y_valid3),
    .y_last(y_last3), .busy(busy3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_word(input logic [15:0] w);
    for (int i = 0; i < 16; i++) exp_q.push_back(w[i]);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_valid3 = 1'b0; in_data3 = '0;
    repeat (2) @(negedge clk);
    assertions++; if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    assertions++; if (y_valid !== 1'b0) begin failures++; $display("FAIL reset_y_valid: got %b expected 0", y_valid); end
    assertions++; if (y !== 1'b0)       begin failures++; $display("FAIL reset_y: got %b expected 0", y); end
    assertions++; if (y_last !== 1'b0)  begin failures++; $display("FAIL reset_y_last: got %b expected 0", y_last); end
    assertions++; if (sel !== 4'd0)     begin failures++; $display("FAIL reset_sel: got %0d expected 0", sel); end
    rst = 1'b0;
    @(negedge clk);
    assertions++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_single_word();
    logic exp_seq [16] = '{0,0,0,1, 1,1,0,0, 1,1,0,0, 1,1,0,1};
    logic [0:0] eb;
    for (int i = 0; i < 16; i++) exp_q.push_back(exp_seq[i]);
    in_data = 16'hB338; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_data = '0;
    for (int i = 0; i < 16; i++) begin
      eb = exp_q.pop_front();
      assertions++; if (sel !== 4'(i)) begin failures++; $display("FAIL single_sel[%0d]: got %0d expected %0d", i, sel, i); end
      assertions++; if (y !== eb[0])   begin failures++; $display("FAIL single_y[%0d]: got %b expected %b", i, y, eb[0]); end
      assertions++; if (y_valid !== 1'b1) begin failures++; $display("FAIL single_y_valid[%0d]: got %b expected 1", i, y_valid); end
      assertions++; if (y_last !== (i == 15)) begin failures++; $display("FAIL single_y_last[%0d]: got %b expected %b", i, y_last, (i == 15)); end
      assertions++; if (in_ready !== (i == 15)) begin failures++; $display("FAIL single_in_ready[%0d]: got %b expected %b", i, in_ready, (i == 15)); end
      @(negedge clk);
    end
    assertions++; if (busy !== 1'b0)     begin failures++; $display("FAIL single_idle_busy: got %b expected 0", busy); end
    assertions++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_idle_in_ready: got %b expected 1", in_ready); end
    assertions++; if (y_valid !== 1'b0)  begin failures++; $display("FAIL single_idle_y_valid: got %b expected 0", y_valid); end
  endtask

  task automatic test_back_to_back();
    logic [0:0] eb;
    push_word(16'hB338);
    push_word(16'hFFFF);
    in_data = 16'hB338; in_valid = 1'b1;
    @(negedge clk);
    in_data = 16'hFFFF;
    for (int c = 0; c < 32; c++) begin
      eb = exp_q.pop_front();
      assertions++; if (sel !== 4'(c % 16)) begin failures++; $display("FAIL b2b_sel[%0d]: got %0d expected %0d", c, sel, c % 16); end
      assertions++; if (y !== eb[0])        begin failures++; $display("FAIL b2b_y[%0d]: got %b expected %b", c, y, eb[0]); end
      assertions++; if (y_valid !== 1'b1)   begin failures++; $display("FAIL b2b_y_valid[%0d]: got %b expected 1", c, y_valid); end
      assertions++; if (in_ready !== (c % 16 == 15)) begin failures++; $display("FAIL b2b_in_ready[%0d]: got %b expected %b", c, in_ready, (c % 16 == 15)); end
      if (c == 16) begin in_valid = 1'b0; in_data = '0; end
      @(negedge clk);
    end
    assertions++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_end_busy: got %b expected 0", busy); end
  endtask

  task automatic test_bit_hold();
    int busy_cnt = 0;
    int last_cnt = 0;
    in_data3 = 16'h0001; in_valid3 = 1'b1;
    @(negedge clk);
    in_valid3 = 1'b0; in_data3 = '0;
    for (int c = 0; c < 60; c++) begin
      if (busy3) begin
        busy_cnt++;
        if (y_last3) last_cnt++;
        assertions++; if (y3 !== (busy_cnt <= 3)) begin failures++; $display("FAIL hold_y[%0d]: got %b expected %b", busy_cnt, y3, (busy_cnt <= 3)); end
      end
      @(negedge clk);
    end
    assertions++; if (busy_cnt != 48) begin failures++; $display("FAIL hold_busy_cycles: got %0d expected 48", busy_cnt); end
    assertions++; if (last_cnt != 3)  begin failures++; $display("FAIL hold_y_last_cycles: got %0d expected 3", last_cnt); end
  endtask

  task automatic test_backpressure();
    logic [0:0] eb;
    push_word(16'h00F0);
    push_word(16'hAAAA);
    in_data = 16'h00F0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_data = '0;
    for (int c = 0; c < 32; c++) begin
      eb = exp_q.pop_front();
      assertions++; if (sel !== 4'(c % 16)) begin failures++; $display("FAIL bp_sel[%0d]: got %0d expected %0d", c, sel, c % 16); end
      assertions++; if (y !== eb[0])        begin failures++; $display("FAIL bp_y[%0d]: got %b expected %b", c, y, eb[0]); end
      assertions++; if (in_ready !== (c % 16 == 15)) begin failures++; $display("FAIL bp_in_ready[%0d]: got %b expected %b", c, in_ready, (c % 16 == 15)); end
      if (c == 5)  begin in_data = 16'hAAAA; in_valid = 1'b1; end
      if (c == 16) begin in_valid = 1'b0; in_data = '0; end
      @(negedge clk);
    end
    assertions++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_end_busy: got %b expected 0", busy); end
  endtask

  task automatic test_midword_reset();
    logic [0:0] eb;
    in_data = 16'hFFFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_data = '0;
    repeat (7) @(negedge clk);
    assertions++; if (sel !== 4'd7) begin failures++; $display("FAIL mid_pre_sel: got %0d expected 7", sel); end
    #2 rst = 1'b1;
    #1;
    assertions++; if (y_valid !== 1'b0) begin failures++; $display("FAIL mid_y_valid: got %b expected 0", y_valid); end
    assertions++; if (y !== 1'b0)       begin failures++; $display("FAIL mid_y: got %b expected 0", y); end
    assertions++; if (y_last !== 1'b0)  begin failures++; $display("FAIL mid_y_last: got %b expected 0", y_last); end
    assertions++; if (busy !== 1'b0)    begin failures++; $display("FAIL mid_busy: got %b expected 0", busy); end
    assertions++; if (sel !== 4'd0)     begin failures++; $display("FAIL mid_sel: got %0d expected 0", sel); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    assertions++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
    push_word(16'h8001);
    in_data = 16'h8001; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_data = '0;
    for (int i = 0; i < 16; i++) begin
      eb = exp_q.pop_front();
      assertions++; if (sel !== 4'(i)) begin failures++; $display("FAIL mid_after_sel[%0d]: got %0d expected %0d", i, sel, i); end
      assertions++; if (y !== eb[0])   begin failures++; $display("FAIL mid_after_y[%0d]: got %b expected %b", i, y, eb[0]); end
      assertions++; if (y_last !== (i == 15)) begin failures++; $display("FAIL mid_after_y_last[%0d]: got %b expected %b", i, y_last, (i == 15)); end
      @(negedge clk);
    end
    assertions++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_after_idle: got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_bit_hold();
    test_backpressure();
    test_midword_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/mux16_serializer.md
# mux16_serializer

Parallel-to-serial front end for the 16:1 multiplexer. It accepts a 16-bit word over a valid/ready handshake and holds it in a register. It then steps the 4-bit select through 0..15, so the existing `mux16to1` emits the word one bit at a time, LSB first. It sits directly upstream of `mux16to1`, owns that mux as its only sub-module, and presents the serial bit with framing flags to downstream logic.

## Interface
- `BIT_CYCLES`, default 1: clock cycles each bit is held on `y`. Legal range 1..255; a value of 0 is illegal.

- `clk`  input  1  rising-edge clock; the block has one clock domain.
- `rst`  input  1  asynchronous, active-high reset.
- `in_data`  input  16  parallel word to serialize.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  block can accept a word this cycle.
- `sel`  output  4  current bit index, also driven into `mux16to1`.
- `y`  output  1  serial bit, equal to `data_q[sel]` from the mux.
- `y_valid`  output  1  `y` carries a live bit.
- `y_last`  output  1  `y` is bit 15 of the current word.
- `busy`  output  1  a word is being shifted.

## Operation
- FSM states:
  - IDLE: `in_ready`=1, `y_valid`=0.
  - SHIFT: `y_valid`=1.
- Capture: a word is taken when `in_valid & in_ready` is high at a rising edge. `in_data` goes to `data_q`, `sel`←0, bit counter←0, state→SHIFT.
- In SHIFT the bit counter counts 0..`BIT_CYCLES`-1. On terminal count, `sel` increments by 1.
- At `sel`=15 with terminal count:
  - If `in_valid`=1: capture a new word. `sel` wraps to 0 and state stays SHIFT (back-to-back, no bubble).
  - Otherwise: state→IDLE and `sel`←0.
- `in_ready` = (state==IDLE) | (state==SHIFT & `sel`==15 & terminal count). It is combinational from state and counters only, with no path from `in_valid`.
- `y` is gated to 0 when `y_valid`=0.
- `y_last` = SHIFT & `sel`==15.
- `busy` = (state==SHIFT).
- `in_valid` while `in_ready`=0 is ignored. The upstream block must hold the word until it sees the handshake.
- `sel` is never incremented past 15. The 4-bit wrap is explicit, on capture only.
- Reset (asynchronous, any time, including mid-word): state=IDLE, `sel`=0, counter=0, `data_q`=0.
  - Resulting outputs: `y`=0, `y_valid`=0, `y_last`=0, `busy`=0. `in_ready` goes to 1 once `rst` deasserts.
  - The partially sent word is discarded.

## Timing
- Latency: the capture edge is followed by `y`=`in_data[0]` with `y_valid`=1 in the very next cycle.
- Each word occupies exactly 16×`BIT_CYCLES` cycles in SHIFT.
- `y_last` is high for the final `BIT_CYCLES` cycles of the word.
- Sustained throughput with back-to-back `in_valid`: one word per 16×`BIT_CYCLES` cycles, with `y_valid` continuously high.
- `y` changes only after rising edges. The only combinational path from registers to `y` is the mux.

## Structure
- Shared package `mux_pkg`:
  - state enum (IDLE, SHIFT);
  - constants `MUX_WIDTH`=16 and `SEL_W`=4, which `mux16to1` also uses.
- Sub-module: `mux16to1`, instantiated once with `.sel(sel)`, `.in(data_q)`, `.y(mux_y)`.
- Everything else is flat: FSM, bit counter, select counter and data register.

## Test plan
- Reset, then a single word:
  - Stimulus: `rst` pulse; `in_data`=16'hB338 and `in_valid` for one cycle with `BIT_CYCLES`=1.
  - Required response: `y` over 16 cycles is 0,0,0,1,1,1,0,0,1,1,0,0,1,1,0,1, with `sel` 0..15.
  - `y_last` is high only at `sel`=15; state returns to IDLE and `in_ready`=1.
- Back-to-back words:
  - Stimulus: 16'hB338 then 16'hFFFF, with `in_valid` held high.
  - Required response: `in_ready` pulses at `sel`=15. The cycle after the last bit of 16'hB338 shows `sel`=0 and `y`=1, and `y_valid` never drops.
- Bit hold:
  - Stimulus: `BIT_CYCLES`=3, word 16'h0001.
  - Required response: `y`=1 for cycles 1–3, then 0 for 45 cycles; `busy` is high for exactly 48 cycles.
- Backpressure:
  - Stimulus: during SHIFT at `sel`=5, drive `in_valid`=1 with 16'hAAAA.
  - Required response: no capture and no corruption of the current word. 16'hAAAA is taken only at the `sel`=15 terminal count.
- Mid-word reset:
  - Stimulus: assert `rst` asynchronously at `sel`=7.
  - Required response: `y_valid`, `y`, `y_last`, `busy` and `sel` are all 0 immediately, before the next edge.
  - After release, `in_ready`=1, and a new word serializes cleanly from `sel`=0.
